// File: rtl/jzjpcc_memory_arbiter.sv
// ---------------------------------------------------------------------------
// jzjpcc_memory_arbiter
//
// Shares one synchronous-read memory port (1-cycle read latency) between the
// fetch stage (instruction reads) and the memory stage (loads/stores).
// Exactly one access is issued per cycle. The winner's request goes straight
// to the memory in the same cycle. The read response is routed back to its
// owner one cycle later. The losing requester sees a stall.
//
// Ports:
//   clock, reset           - rising-edge clock, synchronous active-low reset
//   fetch_req/fetch_addr   - fetch read request and word address
//   fetch_gnt/fetch_stall  - fetch issued this cycle / fetch must wait
//   fetch_rvalid/rdata     - fetch read response (one cycle after grant)
//   data_req/we/addr/      - memory-stage request: load (we=0) or store
//   data_wdata/byte_mask     (we=1) with store data and byte enables
//   data_gnt/data_stall    - data issued this cycle / data must wait
//   data_rvalid/rdata      - load response (one cycle after grant)
//   mem_en/we/addr/wdata/  - shared memory port, driven by the winner
//   mem_byte_mask
//   mem_rdata              - memory read data, valid the cycle after a read
// ---------------------------------------------------------------------------
module jzjpcc_memory_arbiter #(
  parameter int unsigned MAX_DATA_STREAK = 4  // legal range 1..15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [29:0] fetch_addr,
  output logic        fetch_gnt,
  output logic        fetch_stall,
  output logic        fetch_rvalid,
  output logic [31:0] fetch_rdata,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [29:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_byte_mask,
  output logic        data_gnt,
  output logic        data_stall,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_mask,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] MAX_STREAK = 4'(MAX_DATA_STREAK);

  typedef enum logic [1:0] {
    RESP_NONE  = 2'd0,
    RESP_FETCH = 2'd1,
    RESP_DATA  = 2'd2
  } resp_e;

  resp_e      owner_q;
  logic [3:0] streak_q;
  logic [3:0] streak_d;

  // Grant selection: data normally wins a contest; fetch wins only once the
  // data streak has hit its limit. Everything is held off during reset.
  always_comb begin
    fetch_gnt = 1'b0;
    data_gnt  = 1'b0;
    if (!reset) begin
      fetch_gnt = 1'b0;
      data_gnt  = 1'b0;
    end else if (fetch_req && data_req) begin
      if (streak_q == MAX_STREAK) begin
        fetch_gnt = 1'b1;
      end else begin
        data_gnt = 1'b1;
      end
    end else if (fetch_req) begin
      fetch_gnt = 1'b1;
    end else if (data_req) begin
      data_gnt = 1'b1;
    end else begin
      fetch_gnt = 1'b0;
      data_gnt  = 1'b0;
    end
  end

  // Stalls are suppressed while in reset even if requests are high.
  always_comb begin
    fetch_stall = 1'b0;
    data_stall  = 1'b0;
    if (reset) begin
      fetch_stall = fetch_req & ~fetch_gnt;
      data_stall  = data_req & ~data_gnt;
    end else begin
      fetch_stall = 1'b0;
      data_stall  = 1'b0;
    end
  end

  // Shared memory port mux; an idle port drives all-zero operands.
  always_comb begin
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = 30'd0;
    mem_wdata     = 32'd0;
    mem_byte_mask = 4'd0;
    case ({fetch_gnt, data_gnt})
      2'b10: begin
        mem_en   = 1'b1;
        mem_addr = fetch_addr;
      end
      2'b01: begin
        mem_en    = 1'b1;
        mem_we    = data_we;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
        // Byte enables only mean something for stores.
        if (data_we) begin
          mem_byte_mask = data_byte_mask;
        end else begin
          mem_byte_mask = 4'd0;
        end
      end
      default: begin
        mem_en = 1'b0;
      end
    endcase
  end

  // Streak of contested data wins; any fetch win or fetch going quiet ends it.
  always_comb begin
    streak_d = streak_q;
    if (fetch_gnt || !fetch_req) begin
      streak_d = 4'd0;
    end else if (data_gnt) begin
      if (streak_q == MAX_STREAK) begin
        streak_d = streak_q;
      end else begin
        streak_d = streak_q + 4'd1;
      end
    end else begin
      streak_d = streak_q;
    end
  end

  // Response owner FSM and streak register. Stores and idle cycles leave no
  // response pending; a grant in a reset cycle is impossible, so no stale
  // response can leak out afterwards.
  always_ff @(posedge clock) begin
    if (!reset) begin
      owner_q  <= RESP_NONE;
      streak_q <= 4'd0;
    end else begin
      streak_q <= streak_d;
      case (owner_q)
        RESP_NONE, RESP_FETCH, RESP_DATA: begin
          if (fetch_gnt) begin
            owner_q <= RESP_FETCH;
          end else if (data_gnt && !data_we) begin
            owner_q <= RESP_DATA;
          end else begin
            owner_q <= RESP_NONE;
          end
        end
        default: begin
          owner_q <= RESP_NONE;
        end
      endcase
    end
  end

  assign fetch_rvalid = (owner_q == RESP_FETCH);
  assign data_rvalid  = (owner_q == RESP_DATA);
  assign fetch_rdata  = fetch_rvalid ? mem_rdata : 32'd0;
  assign data_rdata   = data_rvalid ? mem_rdata : 32'd0;

endmodule

// File: doc/jzjpcc_memory_arbiter.md
# jzjpcc_memory_arbiter

Arbitrates the single shared memory port between the fetch stage (instruction reads) and the memory stage (data loads/stores), one access per cycle. The memory stage forwards its execute-stage address, write data and byte mask into this block, and fetch drives its PC word address. The winning request goes combinationally to a synchronous-read memory with 1-cycle read latency. The read response is routed back to its owner one cycle later, and the loser gets a stall.

## Interface
- `MAX_DATA_STREAK`, default 4: consecutive contested data grants allowed before fetch is forced through; legal range 1–15.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `fetch_req` in 1: fetch wants a read this cycle.
- `fetch_addr` in 30 [31:2]: fetch word address.
- `fetch_gnt` out 1: fetch access issued this cycle (combinational).
- `fetch_stall` out 1: `fetch_req & ~fetch_gnt`.
- `fetch_rvalid` out 1: `fetch_rdata` valid (registered).
- `fetch_rdata` out 32: `mem_rdata` when `fetch_rvalid`, else 0.
- `data_req` in 1: memory stage wants an access.
- `data_we` in 1: 1 = store, 0 = load.
- `data_addr` in 30 [31:2]: data word address.
- `data_wdata` in 32: store data.
- `data_byte_mask` in 4: store byte enables.
- `data_gnt` out 1: data access issued this cycle (combinational).
- `data_stall` out 1: `data_req & ~data_gnt`.
- `data_rvalid` out 1: load data valid (registered).
- `data_rdata` out 32: `mem_rdata` when `data_rvalid`, else 0.
- `mem_en` out 1: access issued to memory this cycle.
- `mem_we` out 1: write strobe.
- `mem_addr` out 30 [31:2]: word address.
- `mem_wdata` out 32: write data.
- `mem_byte_mask` out 4: byte enables; 0 on reads.
- `mem_rdata` in 32: read data, valid the cycle after a read issue.

## Operation
- Arbitration, combinational, evaluated every cycle:
  - Only one requester: it wins.
  - Both request: data wins unless `streak == MAX_DATA_STREAK`, in which case fetch wins.
  - Neither requests: `mem_en=0`.
- Memory outputs are muxed from the winner. Fetch drives `mem_we=0` and `mem_byte_mask=0`. Data drives `mem_we=data_we` and `mem_byte_mask=data_we ? data_byte_mask : 0`.
- When `mem_en=0`: `mem_addr`, `mem_wdata` and `mem_byte_mask` are 0.
- Streak counter (4 bits, registered):
  - Increments, saturating at `MAX_DATA_STREAK`, when `data_gnt & fetch_req`.
  - Clears to 0 on `fetch_gnt`, or when `fetch_req=0`.
  - Holds otherwise.
- Response-owner register, a 3-state FSM:
  - States: RESP_NONE, RESP_FETCH, RESP_DATA.
  - Next state is RESP_FETCH on `fetch_gnt`, RESP_DATA on `data_gnt & ~data_we`, and RESP_NONE otherwise (including stores and idle cycles).
  - `fetch_rvalid` is high exactly in RESP_FETCH; `data_rvalid` is high exactly in RESP_DATA.
- Each requester holds its request and operands stable until it sees its grant. The arbiter does not buffer requests.
- `fetch_gnt` and `data_gnt` are never both 1.

## Timing
- Reset is sampled at `posedge clock` while `reset=0`:
  - Owner goes to RESP_NONE and streak to 0.
  - `fetch_rvalid` and `data_rvalid` read 0 from the next cycle.
- While `reset=0`, all grants, `mem_en` and `mem_we` are forced to 0, and both stall outputs are 0.
- Reset asserted mid-operation: a read granted in the cycle `reset` is sampled low produces no rvalid. Its response is discarded.
- Grant-to-issue latency is 0 cycles. Read response latency is 1 cycle (rvalid in cycle N+1 for a grant in cycle N).
- Stores complete in the grant cycle; no response.
- Back-to-back reads from alternating owners return in order, one per cycle, with no bubble.
- Worst-case fetch wait under continuous data traffic is `MAX_DATA_STREAK` cycles.
- Data is never starved by fetch, because fetch only wins at the streak limit and the streak clears on that win.

## Test plan
- **Reset:** hold `reset=0` for 3 cycles with both requests high → all grants, `mem_en`, rvalids and stalls stay 0. Release → first cycle grants data, and `fetch_stall=1`.
- **Single fetch:** `fetch_req=1`, `fetch_addr=0x100`, `mem_rdata=0x00000013` next cycle → `fetch_gnt=1` and `mem_addr=0x100`. Next cycle `fetch_rvalid=1` with `fetch_rdata=0x13`, while `data_rvalid=0` and `data_rdata=0`.
- **Contention with `MAX_DATA_STREAK=4`:** both requests held continuously → data granted 4 cycles, fetch granted on the 5th, then data granted 4 more; the pattern repeats.
- **Store:** `data_req=1`, `data_we=1`, `data_byte_mask=4'b0011`, `data_wdata=0xDEADBEEF`, `data_addr=0x40` → `mem_we=1`, `mem_byte_mask=0011`, `mem_wdata=0xDEADBEEF`. No rvalid on the following cycle.
- **Interleaved reads:** alternate data load at 0x10 and fetch at 0x20 with `fetch_req` dropping in between → rvalids alternate owner correctly, and the streak clears when `fetch_req` drops.
- **Reset during read:** grant a data load while `reset=0` in the same cycle → `data_rvalid` stays 0 next cycle.
